// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the BaseRAM/ExtRAM bridge.
// Optional build macro: SRAM_FAST_READ_EN (two-cycle load, see sram_controller).
package sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ADDR  = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5,
        ST_DONE     = 3'd6
    } sram_state_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_READ  = 2'd1,
        PH_WRITE = 2'd2,
        PH_PULSE = 2'd3
    } sram_phase_t;

    typedef enum logic [1:0] {
        RD_ZERO = 2'd0,
        RD_BASE = 2'd1,
        RD_EXT  = 2'd2
    } rd_src_t;

    localparam logic [8:0]  SRAM_WINDOW_TAG  = 9'h100;
    localparam int          SRAM_BANK_BIT    = 22;
    localparam logic        SRAM_STROBE_IDLE = 1'b1;
    localparam logic [3:0]  SRAM_BE_N_IDLE   = 4'hF;
    localparam logic [19:0] SRAM_ADDR_RST    = 20'h0_0000;

    function automatic logic addr_mapped(input logic [31:0] a);
        return (a[31:23] == SRAM_WINDOW_TAG);
    endfunction

endpackage

// File: rtl/sram_controller_port.sv
// One external SRAM bank: registered pins, tristate data driver, read capture.
module sram_port
    import sram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  sram_phase_t phase,
    input  logic        data_en,
    input  logic        load,
    input  logic        capture,
    input  logic [19:0] word_addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rd_data,
    output logic [19:0] ram_addr,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic [3:0]  ram_be_n,
    inout  wire  [31:0] ram_data
);

    logic [31:0] dout_r;
    logic [31:0] rd_data_r;
    logic [3:0]  be_r;
    logic        de_r;
    logic [3:0]  be_s;

    // The enables are loaded on the same edge the first write strobe is set up.
    assign be_s     = load ? be : be_r;
    assign ram_data = de_r ? dout_r : {32{1'bz}};
    assign rd_data  = rd_data_r;

    // Pin, write-data and read-capture registers for this bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr  <= SRAM_ADDR_RST;
            ram_ce_n  <= SRAM_STROBE_IDLE;
            ram_oe_n  <= SRAM_STROBE_IDLE;
            ram_we_n  <= SRAM_STROBE_IDLE;
            ram_be_n  <= SRAM_BE_N_IDLE;
            dout_r    <= 32'h0000_0000;
            rd_data_r <= 32'h0000_0000;
            be_r      <= 4'h0;
            de_r      <= 1'b0;
        end else begin
            if (load && sel) begin
                ram_addr <= word_addr;
                dout_r   <= wdata;
                be_r     <= be;
            end
            if (capture && sel) begin
                rd_data_r <= ram_data;
            end
            de_r <= sel && data_en;
            if (sel) begin
                case (phase)
                    PH_READ: begin
                        ram_ce_n <= 1'b0;
                        ram_oe_n <= 1'b0;
                        ram_we_n <= 1'b1;
                        ram_be_n <= 4'h0;
                    end
                    PH_WRITE: begin
                        ram_ce_n <= 1'b0;
                        ram_oe_n <= 1'b1;
                        ram_we_n <= 1'b1;
                        ram_be_n <= ~be_s;
                    end
                    PH_PULSE: begin
                        ram_ce_n <= 1'b0;
                        ram_oe_n <= 1'b1;
                        ram_we_n <= 1'b0;
                        ram_be_n <= ~be_s;
                    end
                    default: begin
                        ram_ce_n <= SRAM_STROBE_IDLE;
                        ram_oe_n <= SRAM_STROBE_IDLE;
                        ram_we_n <= SRAM_STROBE_IDLE;
                        ram_be_n <= SRAM_BE_N_IDLE;
                    end
                endcase
            end else begin
                ram_ce_n <= SRAM_STROBE_IDLE;
                ram_oe_n <= SRAM_STROBE_IDLE;
                ram_we_n <= SRAM_STROBE_IDLE;
                ram_be_n <= SRAM_BE_N_IDLE;
            end
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Word load/store bridge to the BaseRAM/ExtRAM asynchronous SRAM banks.
// Build option: SRAM_FAST_READ_EN drops RD_WAIT for a two-cycle load.
module sram_controller
    import sram_pkg::*;
(
    input  logic        clk_50M,
    input  logic        reset_btn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic [19:0] base_ram_addr,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    output logic [3:0]  base_ram_be_n,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n,
    output logic [3:0]  ext_ram_be_n,
    inout  wire  [31:0] ext_ram_data
);

    sram_state_t state_r, state_nx_s;
    sram_phase_t phase_s;
    rd_src_t     rd_src_r;
    logic        data_en_s, mapped_s, start_s, bank_s, capture_s;
    logic        bank_r, ack_r, err_r;
    logic [31:0] base_rd_s, ext_rd_s, rdata_s;

    assign mapped_s = addr_mapped(addr);
    assign start_s  = (state_r == ST_IDLE) && req && mapped_s;
    assign bank_s   = (state_r == ST_IDLE) ? addr[SRAM_BANK_BIT] : bank_r;
`ifdef SRAM_FAST_READ_EN
    assign capture_s = (state_r == ST_RD_ADDR);
`else
    assign capture_s = (state_r == ST_RD_WAIT);
`endif

    // Next-state decode.
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (!req) begin
                    state_nx_s = ST_IDLE;
                end else if (!mapped_s) begin
                    state_nx_s = ST_DONE;
                end else if (we) begin
                    state_nx_s = ST_WR_SETUP;
                end else begin
                    state_nx_s = ST_RD_ADDR;
                end
            end
`ifdef SRAM_FAST_READ_EN
            ST_RD_ADDR:  state_nx_s = ST_DONE;
`else
            ST_RD_ADDR:  state_nx_s = ST_RD_WAIT;
`endif
            ST_RD_WAIT:  state_nx_s = ST_DONE;
            ST_WR_SETUP: state_nx_s = ST_WR_PULSE;
            ST_WR_PULSE: state_nx_s = ST_WR_HOLD;
            ST_WR_HOLD:  state_nx_s = ST_DONE;
            ST_DONE:     state_nx_s = ST_IDLE;
            default:     state_nx_s = ST_IDLE;
        endcase
    end

    // Pin phase follows the state being entered so the bank flops line up with it.
    always_comb begin
        phase_s   = PH_IDLE;
        data_en_s = 1'b0;
        case (state_nx_s)
            ST_RD_ADDR, ST_RD_WAIT: phase_s = PH_READ;
            ST_WR_SETUP, ST_WR_HOLD: begin
                phase_s   = PH_WRITE;
                data_en_s = 1'b1;
            end
            ST_WR_PULSE: begin
                phase_s   = PH_PULSE;
                data_en_s = 1'b1;
            end
            default: begin
                phase_s   = PH_IDLE;
                data_en_s = 1'b0;
            end
        endcase
    end

    // Control FSM with registered ack/err and read-data source.
    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            state_r  <= ST_IDLE;
            bank_r   <= 1'b0;
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
            rd_src_r <= RD_ZERO;
        end else begin
            state_r <= state_nx_s;
            ack_r   <= (state_nx_s == ST_DONE);
            err_r   <= (state_r == ST_IDLE) && req && !mapped_s;
            if (start_s) begin
                bank_r <= addr[SRAM_BANK_BIT];
            end
            if (capture_s) begin
                rd_src_r <= bank_r ? RD_EXT : RD_BASE;
            end else if ((state_r == ST_IDLE) && req && !mapped_s) begin
                rd_src_r <= RD_ZERO;
            end
        end
    end

    // Load data comes straight from the capturing bank's register.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (rd_src_r)
            RD_BASE: rdata_s = base_rd_s;
            RD_EXT:  rdata_s = ext_rd_s;
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    assign ack   = ack_r;
    assign err   = err_r;
    assign rdata = rdata_s;

    sram_port u_base (
        .clk       (clk_50M),
        .rst       (reset_btn),
        .sel       (!bank_s),
        .phase     (phase_s),
        .data_en   (data_en_s),
        .load      (start_s),
        .capture   (capture_s),
        .word_addr (addr[21:2]),
        .wdata     (wdata),
        .be        (be),
        .rd_data   (base_rd_s),
        .ram_addr  (base_ram_addr),
        .ram_ce_n  (base_ram_ce_n),
        .ram_oe_n  (base_ram_oe_n),
        .ram_we_n  (base_ram_we_n),
        .ram_be_n  (base_ram_be_n),
        .ram_data  (base_ram_data)
    );

    sram_port u_ext (
        .clk       (clk_50M),
        .rst       (reset_btn),
        .sel       (bank_s),
        .phase     (phase_s),
        .data_en   (data_en_s),
        .load      (start_s),
        .capture   (capture_s),
        .word_addr (addr[21:2]),
        .wdata     (wdata),
        .be        (be),
        .rd_data   (ext_rd_s),
        .ram_addr  (ext_ram_addr),
        .ram_ce_n  (ext_ram_ce_n),
        .ram_oe_n  (ext_ram_oe_n),
        .ram_we_n  (ext_ram_we_n),
        .ram_be_n  (ext_ram_be_n),
        .ram_data  (ext_ram_data)
    );

endmodule

// File: tb/tb_sram_controller.sv
// Directed, table-driven bench for sram_controller with a small two-bank SRAM model.
module tb_sram_controller;

`ifdef SRAM_FAST_READ_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset_btn, req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ack, err;
    logic [31:0] rdata;
    logic [19:0] base_ram_addr, ext_ram_addr;
    logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
    logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
    logic [3:0]  base_ram_be_n, ext_ram_be_n;
    wire  [31:0] base_ram_data, ext_ram_data;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    sram_controller dut (
        .clk_50M       (clk),
        .reset_btn     (reset_btn),
        .req           (req),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .be            (be),
        .ack           (ack),
        .rdata         (rdata),
        .err           (err),
        .base_ram_addr (base_ram_addr),
        .base_ram_ce_n (base_ram_ce_n),
        .base_ram_oe_n (base_ram_oe_n),
        .base_ram_we_n (base_ram_we_n),
        .base_ram_be_n (base_ram_be_n),
        .base_ram_data (base_ram_data),
        .ext_ram_addr  (ext_ram_addr),
        .ext_ram_ce_n  (ext_ram_ce_n),
        .ext_ram_oe_n  (ext_ram_oe_n),
        .ext_ram_we_n  (ext_ram_we_n),
        .ext_ram_be_n  (ext_ram_be_n),
        .ext_ram_data  (ext_ram_data)
    );

    // SRAM model: 256 words per bank; a write latched during the we_n pulse
    // only lands if the chip is still enabled one cycle later.
    logic [31:0] base_mem [0:255];
    logic [31:0] ext_mem  [0:255];
    logic        b_pend = 1'b0, e_pend = 1'b0;
    logic [7:0]  b_idx, e_idx;
    logic [31:0] b_dat, e_dat;
    logic [3:0]  b_ben, e_ben;

    assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n && base_ram_we_n) ?
                           base_mem[base_ram_addr[7:0]] : {32{1'bz}};
    assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n && ext_ram_we_n) ?
                           ext_mem[ext_ram_addr[7:0]] : {32{1'bz}};

    always @(negedge clk) begin
        if (b_pend && !base_ram_ce_n) begin
            for (int k = 0; k < 4; k++)
                if (!b_ben[k]) base_mem[b_idx][8*k +: 8] <= b_dat[8*k +: 8];
        end
        b_pend <= !base_ram_ce_n && !base_ram_we_n;
        b_idx  <= base_ram_addr[7:0];
        b_dat  <= base_ram_data;
        b_ben  <= base_ram_be_n;
    end

    always @(negedge clk) begin
        if (e_pend && !ext_ram_ce_n) begin
            for (int k = 0; k < 4; k++)
                if (!e_ben[k]) ext_mem[e_idx][8*k +: 8] <= e_dat[8*k +: 8];
        end
        e_pend <= !ext_ram_ce_n && !ext_ram_we_n;
        e_idx  <= ext_ram_addr[7:0];
        e_dat  <= ext_ram_data;
        e_ben  <= ext_ram_be_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-transaction pin observations, sampled on falling edges.
    logic        base_seen, ext_seen, addr_unstable;
    logic [19:0] seen_addr;
    logic [3:0]  seen_be_n;
    int          we_low;

    task automatic sample();
        if (!base_ram_ce_n) begin
            if (base_seen && base_ram_addr != seen_addr) addr_unstable = 1'b1;
            base_seen = 1'b1;
            seen_addr = base_ram_addr;
            seen_be_n = base_ram_be_n;
            if (!base_ram_we_n) we_low++;
        end
        if (!ext_ram_ce_n) begin
            if (ext_seen && ext_ram_addr != seen_addr) addr_unstable = 1'b1;
            ext_seen  = 1'b1;
            seen_addr = ext_ram_addr;
            seen_be_n = ext_ram_be_n;
            if (!ext_ram_we_n) we_low++;
        end
    endtask

    // Issue one request (called just after a rising edge, controller idle).
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output int lat, output logic got_err,
                          output logic [31:0] got_rdata);
        base_seen = 1'b0; ext_seen = 1'b0; addr_unstable = 1'b0; we_low = 0;
        seen_addr = 20'h0; seen_be_n = 4'h0;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        lat = 0;
        @(negedge clk); sample();
        while (!ack && lat < 50) begin
            lat++;
            @(negedge clk); sample();
        end
        got_err   = err;
        got_rdata = rdata;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        int          bank;      // 0 none, 1 BaseRAM, 2 ExtRAM
        logic [19:0] ram_addr;
        logic [3:0]  be_n;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int          lat, gap, ack_cnt;
    logic        got_err;
    logic [31:0] got_rd;

    initial begin
        vecs[0]  = '{1'b1, 32'h8030_0000, 32'h0000_0004, 4'hF, 4, 1'b0, 1'b0, 32'h0, 1, 20'hC0000, 4'h0};
        vecs[1]  = '{1'b0, 32'h8030_0000, 32'h0, 4'h0, RD_LAT, 1'b0, 1'b1, 32'h0000_0004, 1, 20'hC0000, 4'h0};
        vecs[2]  = '{1'b1, 32'h8040_0005, 32'h0000_AB00, 4'b0010, 4, 1'b0, 1'b0, 32'h0, 2, 20'h00001, 4'b1101};
        vecs[3]  = '{1'b0, 32'h8040_0004, 32'h0, 4'h0, RD_LAT, 1'b0, 1'b1, 32'hE000_AB01, 2, 20'h00001, 4'h0};
        vecs[4]  = '{1'b0, 32'h1000_0005, 32'h0, 4'h0, 1, 1'b1, 1'b1, 32'h0, 0, 20'h0, 4'h0};
        vecs[5]  = '{1'b0, 32'h8040_0008, 32'h0, 4'h0, RD_LAT, 1'b0, 1'b1, 32'hE000_0002, 2, 20'h00002, 4'h0};
        vecs[6]  = '{1'b1, 32'h8080_0000, 32'h1234_5678, 4'hF, 1, 1'b1, 1'b1, 32'h0, 0, 20'h0, 4'h0};
        vecs[7]  = '{1'b0, 32'h807F_FFFC, 32'h0, 4'h0, RD_LAT, 1'b0, 1'b1, 32'hE000_00FF, 2, 20'hFFFFF, 4'h0};
        vecs[8]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, RD_LAT, 1'b0, 1'b1, 32'hB000_0004, 1, 20'h00004, 4'h0};
        vecs[9]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'b1001, 4, 1'b0, 1'b0, 32'h0, 1, 20'h00004, 4'b0110};
        vecs[10] = '{1'b0, 32'h8000_0013, 32'h0, 4'h0, RD_LAT, 1'b0, 1'b1, 32'h1100_0044, 1, 20'h00004, 4'h0};

        for (int i = 0; i < 256; i++) begin
            base_mem[i] = 32'hB000_0000 + 32'(i);
            ext_mem[i]  = 32'hE000_0000 + 32'(i);
        end

        reset_btn = 1'b1; req = 1'b0; we = 1'b0;
        addr = 32'h0; wdata = 32'h0; be = 4'h0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_base_ce_n", base_ram_ce_n, 1'b1);
        check("rst_base_oe_n", base_ram_oe_n, 1'b1);
        check("rst_base_we_n", base_ram_we_n, 1'b1);
        check("rst_base_be_n", base_ram_be_n, 4'hF);
        check("rst_base_addr", base_ram_addr, 20'h0);
        check("rst_ext_ce_n", ext_ram_ce_n, 1'b1);
        check("rst_ext_oe_n", ext_ram_oe_n, 1'b1);
        check("rst_ext_we_n", ext_ram_we_n, 1'b1);
        check("rst_ext_be_n", ext_ram_be_n, 4'hF);
        check("rst_ack", ack, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        reset_btn = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, got_err, got_rd);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_err", i), got_err, vecs[i].err);
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), got_rd, vecs[i].rdata);
            check($sformatf("v%0d_base_ce_used", i), base_seen, vecs[i].bank == 1);
            check($sformatf("v%0d_ext_ce_used", i), ext_seen, vecs[i].bank == 2);
            check($sformatf("v%0d_we_pulse_cycles", i), we_low,
                  (vecs[i].we && vecs[i].bank != 0) ? 1 : 0);
            check($sformatf("v%0d_addr_stable", i), addr_unstable, 1'b0);
            if (vecs[i].bank != 0) begin
                check($sformatf("v%0d_ram_addr", i), seen_addr, vecs[i].ram_addr);
                check($sformatf("v%0d_be_n", i), seen_be_n, vecs[i].be_n);
            end
        end

        // Two loads with req held high: acks one read period apart.
        req = 1'b1; we = 1'b0; addr = 32'h8040_0008; be = 4'h0;
        lat = 0;
        @(negedge clk);
        while (!ack && lat < 50) begin lat++; @(negedge clk); end
        check("b2b_first_latency", lat, RD_LAT);
        check("b2b_first_rdata", rdata, 32'hE000_0002);
        @(posedge clk); #1;
        addr = 32'h8000_0010;
        gap = 1;
        @(negedge clk);
        while (!ack && gap < 50) begin gap++; @(negedge clk); end
        check("b2b_ack_spacing", gap, RD_LAT + 1);
        check("b2b_second_rdata", rdata, 32'h1100_0044);
        @(posedge clk); #1;
        req = 1'b0;

        // Reset during WR_PULSE: pins idle at once, no ack, word untouched.
        req = 1'b1; we = 1'b1; addr = 32'h8040_0010; wdata = 32'hFFFF_FFFF; be = 4'hF;
        repeat (3) @(negedge clk);
        check("abort_in_pulse", ext_ram_we_n, 1'b0);
        reset_btn = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("abort_we_n", ext_ram_we_n, 1'b1);
        check("abort_ce_n", ext_ram_ce_n, 1'b1);
        check("abort_be_n", ext_ram_be_n, 4'hF);
        check("abort_addr", ext_ram_addr, 20'h0);
        @(posedge clk); #1;
        reset_btn = 1'b0;
        ack_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack) ack_cnt++;
        end
        check("abort_no_ack", ack_cnt, 0);
        @(posedge clk); #1;
        do_req(1'b0, 32'h8040_0010, 32'h0, 4'h0, lat, got_err, got_rd);
        check("abort_word_unchanged", got_rd, 32'hE000_0004);
        check("abort_reload_latency", lat, RD_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Bus-to-SRAM bridge inside `riscv_cpu_top`, directly downstream of the CPU memory-access path. It accepts one word-wide load/store request at a time and drives the two external 32-bit asynchronous SRAM banks (BaseRAM and ExtRAM) through a fixed multi-cycle state machine. It returns read data or a write completion with a single-cycle acknowledge.

## Interface
- No parameters; the address map is fixed by package constants.
- `clk_50M` in 1 — system clock, 50 MHz.
- `reset_btn` in 1 — synchronous, active-high reset.
- `req` in 1 — request valid; requester holds `req`, `we`, `addr`, `wdata`, `be` stable until `ack`.
- `we` in 1 — 1 = store, 0 = load.
- `addr` in 32 — byte address.
- `wdata` in 32 — store data; byte lanes are little-endian.
- `be` in 4 — active-high byte enables for stores; ignored for loads.
- `ack` out 1 — one-cycle completion pulse.
- `rdata` out 32 — load data, valid while `ack`=1 and held until the next `ack`.
- `err` out 1 — asserted together with `ack` when the address is unmapped.
- `base_ram_addr` out 20 — BaseRAM word address.
- `base_ram_ce_n`, `base_ram_oe_n`, `base_ram_we_n` out 1 each — BaseRAM strobes, active-low.
- `base_ram_be_n` out 4 — BaseRAM byte enables, active-low.
- `base_ram_data` inout 32 — BaseRAM data bus.
- `ext_ram_*` — same set of signals as `base_ram_*`, for the ExtRAM bank.

## Operation
- **Address decode:**
  - `addr[31:23]` == 9'h100 is the mapped window 0x8000_0000–0x807F_FFFF.
  - `addr[22]` = 0 selects BaseRAM; `addr[22]` = 1 selects ExtRAM.
  - The SRAM word address is `addr[21:2]`. `addr[1:0]` is ignored.
- **Unmapped addresses:** no SRAM strobe is asserted; the block returns `ack`=1, `err`=1, `rdata`=0.
- **States:** IDLE, RD_ADDR, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
  - IDLE with `req`=1 registers the request. Next state is RD_ADDR (load), WR_SETUP (store) or DONE (unmapped).
  - RD_ADDR → RD_WAIT → DONE. `rdata` is captured at the end of RD_WAIT.
  - WR_SETUP → WR_PULSE → WR_HOLD → DONE.
  - DONE: `ack`=1 for one cycle, then IDLE.
- **Strobes during reads:** selected bank has `ce_n`=0, `oe_n`=0, `be_n`=4'b0000; data bus is hi-Z.
- **Strobes during writes:**
  - Selected bank has `ce_n`=0, `oe_n`=1, `be_n`=~`be`.
  - Data is driven for all three write states.
  - `we_n`=0 only in WR_PULSE.
- **Unselected bank:** `ce_n`, `oe_n`, `we_n` = 1, `be_n`=4'hF, data hi-Z, address held.
- **Back-to-back requests:** `req` held high after `ack` is taken as a new request on the following IDLE cycle. The requester updates or drops `req` on the edge where it sees `ack`.

## Timing
- **Reset values:** all `ce_n`/`oe_n`/`we_n`=1, `be_n`=4'hF, addresses 0, data buses hi-Z, `ack`=0, `err`=0, `rdata`=0, state IDLE.
- **Latency** (cycle 0 = IDLE cycle that samples `req`):
  - Load: `ack` in cycle 3.
  - Store: `ack` in cycle 4.
  - Unmapped access: `ack` in cycle 1.
- **Throughput:** one request per 4 cycles for loads and per 5 cycles for stores, because DONE → IDLE costs one cycle.
- **Address/strobe stability:** address and `be_n` are stable one cycle before the `we_n` fall and one cycle after its rise. There is no address change while `we_n`=0.
- **Reset mid-operation:** the state machine aborts at the reset edge. All pins return to reset values on that edge. No `ack` is issued for the aborted request.
- **Output registration:** all SRAM pin outputs come from flops. There are no combinational paths from `req` to the pins.

## Configuration
- **`SRAM_FAST_READ_EN` defined:**
  - RD_WAIT is skipped; RD_ADDR → DONE and `rdata` is captured at the end of RD_ADDR.
  - Load `ack` arrives in cycle 2.
- **`SRAM_FAST_READ_EN` undefined:** the 3-cycle load described above. This is the default, and the safe setting for 10 ns parts plus board delay.
- Store timing is identical in both builds.

## Structure
- **`sram_pkg`:**
  - State enum `sram_state_t`.
  - Constants `SRAM_WINDOW_TAG` = 9'h100 and `SRAM_BANK_BIT` = 22.
  - Constants for idle pin values.
- **`sram_port` sub-module:**
  - One instance per bank.
  - Contains the registered `addr`/`ce_n`/`oe_n`/`we_n`/`be_n` flops, the tristate data driver and the read-data capture.
  - Driven by `sram_controller` through a select, a phase and a data-enable.

## Test plan
- **Reset:** hold `reset_btn` for 5 cycles → both banks `ce_n`/`oe_n`/`we_n`=1, `be_n`=F, data Z; `ack`=0.
- **Word store:** store 0x8030_0000, data 0x0000_0004, `be`=F → BaseRAM addr 0xC0000, `we_n` low exactly 1 cycle, `ack` in cycle 4. The model word then reads 0x0000_0004.
- **Load-back:** load 0x8030_0000 → `rdata`=0x0000_0004, `ack` in cycle 3 (cycle 2 with `SRAM_FAST_READ_EN`). ExtRAM `ce_n` stays 1.
- **Byte store:** store 0x8040_0005, data 0x0000_AB00, `be`=4'b0010 → ExtRAM addr 1, `be_n`=4'b1101. A subsequent load returns byte 1 = 0xAB with the other bytes unchanged.
- **Unmapped access:** load 0x1000_0005 → `ack` and `err` in cycle 1, `rdata`=0, no `ce_n` asserted on either bank.
- **Back-to-back and reset:**
  - Two loads with `req` held high give `ack` 4 cycles apart.
  - `reset_btn` asserted during WR_PULSE → `we_n`=1 at the next edge, no `ack`, target word unchanged.
